spi_pixel_rx: RTL and testbench

//  SPI-mode-0 slave: receives one video line per CS_n burst from an external camera/sender board.

---
 rtl/spi_pixel_rx_pkg.sv | 11 +
 rtl/spi_pixel_rx_if.sv | 11 +
 rtl/spi_pixel_rx_fifo.sv | 36 +++
 rtl/spi_pixel_rx.sv | 155 +++++++++++++++
 tb/tb_spi_pixel_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pixel_rx_pkg.sv
// spi_pixel_rx_pkg: shared types and constants for the SPI pixel receiver.
package spi_pixel_rx_pkg;
    localparam int PIX_W       = 24;
    localparam int CMD_SOF_BIT = 0;
    typedef enum logic [2:0] {IDLE, CMD, PIX_R, PIX_G, PIX_B, FLUSH} state_e;
    typedef struct packed {
        logic              tuser;
        logic              tlast;
        logic [PIX_W-1:0]  rgb;
    } entry_t;
endpackage

// File: rtl/spi_pixel_rx_if.sv
// spi_pixel_rx_if: AXI4-Stream pixel channel carrying {R,G,B} with SOF/EOL marks.
interface spi_pixel_rx_if;
    import spi_pixel_rx_pkg::*;
    logic [PIX_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tuser;
    logic             tlast;
    modport master(output tdata, tvalid, tuser, tlast, input tready);
    modport slave(input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/spi_pixel_rx_fifo.sv
// spi_pixel_rx_fifo: synchronous FIFO, pointers carry an extra wrap bit; push on full accepted only with a pop.
module spi_pixel_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_i,
    input  logic                   rd_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         we, re;
    assign level_o = wp_q - rp_q;
    assign full_o  = level_o == (AW+1)'(DEPTH);
    assign empty_o = wp_q == rp_q;
    assign we      = wr_i && (!full_o || rd_i);
    assign re      = rd_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (we) wp_q <= wp_q + 1'b1;
            if (re) rp_q <= rp_q + 1'b1;
        end
    always_ff @(posedge clk)
        if (we) mem_q[wp_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: SPI mode-0 slave turning one CS_n burst (CMD byte + RGB bytes) into an AXIS video line.
// Optional status readout on miso during the CMD byte when SPI_PIXEL_RX_STATUS_EN is defined.
module spi_pixel_rx
    import spi_pixel_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic sysclk,
    input  logic rst,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_n_i,
    output logic miso_o,
    output logic overflow_o,
    output logic frame_err_o,
    spi_pixel_rx_if.master m_axis
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [SYNC_STAGES:0]   sclk_q, cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    state_e                 st_q;
    logic [2:0]             cnt_q;
    logic [6:0]             sr_q;
    logic [7:0]             r_q, g_q, byte_w;
    logic [PIX_W:0]         hold_q;
    logic                   hold_v_q, sof_q, part_q, push_q, ovf_q, ferr_q;
    entry_t                 push_data_q, rd_data;
    logic                   fifo_full, fifo_empty;
    logic [LW-1:0]          fifo_level;
    logic                   rise, cs_fall, cs_rise, byte_done, active, pop, drop;

    // The top bit of each chain is the previous synced value, used only for edge detection.
    always_ff @(posedge sysclk or posedge rst)
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk_i};
            cs_q   <= {cs_q[SYNC_STAGES-1:0], cs_n_i};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
        end

    assign rise      = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign byte_w    = {sr_q, mosi_q[SYNC_STAGES-1]};
    assign byte_done = rise && cnt_q == 3'd7;
    assign active    = st_q inside {CMD, PIX_R, PIX_G, PIX_B};
    assign pop       = m_axis.tvalid & m_axis.tready;
    assign drop      = push_q & fifo_full & ~pop;

    always_ff @(posedge sysclk or posedge rst)
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            r_q         <= '0;
            g_q         <= '0;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            sof_q       <= 1'b0;
            part_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (drop) ovf_q <= 1'b1;
            if (rise && active) begin
                sr_q  <= byte_w[6:0];
                cnt_q <= cnt_q + 3'd1;
            end
            case (st_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (cs_fall) st_q <= CMD;
                end
                FLUSH: begin
                    push_q      <= hold_v_q;
                    push_data_q <= {hold_q[PIX_W], 1'b1, hold_q[PIX_W-1:0]};
                    hold_v_q    <= 1'b0;
                    if (part_q) ferr_q <= 1'b1;
                    st_q        <= IDLE;
                end
                default:
                    if (cs_rise) begin
                        part_q <= st_q inside {PIX_G, PIX_B};
                        st_q   <= FLUSH;
                    end else if (byte_done) begin
                        if (st_q == CMD) begin
                            sof_q <= byte_w[CMD_SOF_BIT];
                            if (byte_w[CMD_SOF_BIT]) begin
                                ovf_q  <= 1'b0;
                                ferr_q <= 1'b0;
                            end
                            st_q <= PIX_R;
                        end else if (st_q == PIX_R) begin
                            r_q  <= byte_w;
                            st_q <= PIX_G;
                        end else if (st_q == PIX_G) begin
                            g_q  <= byte_w;
                            st_q <= PIX_B;
                        end else begin
                            push_q      <= hold_v_q;
                            push_data_q <= {hold_q[PIX_W], 1'b0, hold_q[PIX_W-1:0]};
                            hold_q      <= {sof_q, r_q, g_q, byte_w};
                            hold_v_q    <= 1'b1;
                            sof_q       <= 1'b0;
                            st_q        <= PIX_R;
                        end
                    end
            endcase
        end

    spi_pixel_rx_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
        .clk(sysclk),
        .rst(rst),
        .wr_i(push_q),
        .rd_i(pop),
        .wdata_i(push_data_q),
        .rdata_o(rd_data),
        .full_o(fifo_full),
        .empty_o(fifo_empty),
        .level_o(fifo_level)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = rd_data;
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;

`ifdef SPI_PIXEL_RX_STATUS_EN
    logic       fall, miso_q;
    logic [6:0] stat_q;
    logic [3:0] lvl_sat;
    logic [7:0] status;
    assign fall    = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign lvl_sat = 32'(fifo_level) > 15 ? 4'hF : 4'(fifo_level);
    assign status  = {ovf_q, ferr_q, fifo_full, fifo_empty, lvl_sat};
    always_ff @(posedge sysclk or posedge rst)
        if (rst) {miso_q, stat_q} <= '0;
        else if (st_q == IDLE && cs_fall) {miso_q, stat_q} <= status;
        else if (st_q == CMD) begin
            if (fall) {miso_q, stat_q} <= {stat_q, 1'b0};
        end else miso_q <= 1'b0;
    assign miso_o = miso_q;
`else
    logic unused_level;
    assign unused_level = ^fifo_level;
    assign miso_o       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_pixel_rx.sv
// tb_spi_pixel_rx: random-stimulus bench with a line-level model of the expected pixel stream and flags.
module tb_spi_pixel_rx;
    localparam int DEPTH = 16;
    localparam int H     = 8;
    logic sysclk = 0, rst = 1, sclk = 0, mosi = 0, cs_n = 1;
    logic miso, overflow, frame_err;
    int   checks = 0, errors = 0, rmode = 1;
    logic [7:0]  bq[$];
    logic [25:0] exp_q[$], got_q[$];
    logic        exp_ovf = 0, exp_ferr = 0;
    logic        pv = 0, pr = 0;
    logic [25:0] pd, beat, e;

    spi_pixel_rx_if axis();
    spi_pixel_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
        .sysclk(sysclk), .rst(rst), .sclk_i(sclk), .mosi_i(mosi), .cs_n_i(cs_n),
        .miso_o(miso), .overflow_o(overflow), .frame_err_o(frame_err), .m_axis(axis.master)
    );

    always #5 sysclk = ~sysclk;

    initial forever begin
        @(posedge sysclk);
        #1 axis.tready = rmode == 2 ? 1'($urandom) : rmode == 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every accepted beat is matched against the model; a stalled beat must not change.
    initial forever begin
        @(negedge sysclk);
        beat = {axis.tuser, axis.tlast, axis.tdata};
        if (rst) pv = 0;
        else begin
            if (pv && !pr) chk("stall_hold", {axis.tvalid, 5'd0, beat}, {1'b1, 5'd0, pd});
            if (axis.tvalid && axis.tready) begin
                got_q.push_back(beat);
                if (exp_q.size() == 0) chk("extra_beat", beat, 26'h3FFFFFF ^ beat);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", beat, e);
                end
            end
            pv = axis.tvalid;
            pr = axis.tready;
            pd = beat;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        r = 0;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            tick(H);
            sclk = 1;
            r[i] = miso;
            tick(H);
            sclk = 0;
        end
    endtask

    task automatic lit(input logic [63:0] v, input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic mk(input logic [7:0] cmd, input int npix);
        bq.delete();
        bq.push_back(cmd);
        repeat (3 * npix) bq.push_back(8'($urandom));
    endtask

    task automatic burst(input int xbits, input logic ovf_mode);
        int n = bq.size();
        int np = n > 0 ? (n - 1) / 3 : 0;
        logic sof = n > 0 && bq[0][0];
        logic [7:0] es, r, mor = 0;
`ifdef SPI_PIXEL_RX_STATUS_EN
        es = {exp_ovf, exp_ferr, 2'b01, 4'h0};
`else
        es = 0;
`endif
        if (sof) begin
            exp_ovf = 0;
            exp_ferr = 0;
        end
        for (int p = 0; p < np; p++)
            if (!ovf_mode || p < DEPTH)
                exp_q.push_back({sof && p == 0, p == np - 1, bq[1+3*p], bq[2+3*p], bq[3+3*p]});
            else exp_ovf = 1;
        if (n > 0 && (n - 1) % 3 != 0) exp_ferr = 1;
        cs_n = 0;
        tick(H);
        for (int i = 0; i < n; i++) begin
            xfer(bq[i], r);
            if (i == 0) chk("miso_status", r, es);
            else mor |= r;
        end
        for (int i = 0; i < xbits; i++) begin
            mosi = 1'($urandom);
            tick(H);
            sclk = 1;
            tick(H);
            sclk = 0;
        end
        tick(H);
        cs_n = 1;
        tick(30);
        if (n > 1) chk("miso_after_cmd", mor, 0);
        chk("overflow", overflow, exp_ovf);
        chk("frame_err", frame_err, exp_ferr);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            tick(1);
            t++;
        end
        tick(5);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] r;
        int nl;
        tick(5);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_flags", {overflow, frame_err, miso}, 0);
        rst = 0;
        tick(5);

        got_q.delete();
        lit(64'h01FF000000FF00, 7);
        burst(0, 0);
        drain();
        chk("sof_beat0", got_q[0], 26'h2FF0000);
        chk("sof_beat1", got_q[1], 26'h100FF00);

        got_q.delete();
        mk(8'h00, 4);
        burst(0, 0);
        drain();
        chk("line_beats", got_q.size(), 4);

        got_q.delete();
        lit(64'h0011223344, 5);
        burst(0, 0);
        drain();
        chk("partial_beat", got_q[0], 26'h1112233);
        chk("partial_ferr", frame_err, 1);
        lit(64'h01AABBCC, 4);
        burst(0, 0);
        drain();
        chk("sof_clears_ferr", frame_err, 0);

        got_q.delete();
        rmode = 0;
        mk(8'h00, DEPTH + 2);
        burst(0, 1);
        chk("ovf_set", overflow, 1);
        rmode = 1;
        drain();
        chk("ovf_kept", got_q.size(), DEPTH);

        mk(8'h01, 1);
        burst(0, 0);
        drain();
        mk(8'h00, 1);
        burst(3, 0);
        drain();
        mk(8'h00, 1);
        bq.push_back(8'h5A);
        burst(5, 0);
        drain();

        got_q.delete();
        rmode = 2;
        mk(8'($urandom_range(0, 1)), 64);
        burst(0, 0);
        drain();
        rmode = 1;
        nl = 0;
        foreach (got_q[i]) nl += int'(got_q[i][24]);
        chk("long_tlast", nl, 1);
        chk("long_beats", got_q.size(), 64);

        lit(64'h0055, 2);
        burst(0, 0);
        cs_n = 0;
        tick(H);
        xfer(8'h00, r);
        xfer(8'hAB, r);
        mosi = 1;
        tick(H);
        sclk = 1;
        tick(H);
        sclk = 0;
        rst = 1;
        @(negedge sysclk);
        chk("rst_mid_flags", {axis.tvalid, overflow, frame_err, miso}, 0);
        chk("rst_mid_tdata", 32'(axis.tdata), 0);
        exp_ovf = 0;
        exp_ferr = 0;
        cs_n = 1;
        tick(3);
        rst = 0;
        tick(5);
        got_q.delete();
        lit(64'h01102030405060, 7);
        burst(0, 0);
        drain();
        chk("post_rst_beat0", got_q[0], 26'h2102030);
        chk("post_rst_beat1", got_q[1], 26'h1405060);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
